// File: rtl/clock_monitor_pkg.sv
// Shared types and constants for the clock frequency monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } state_t;

  localparam int SYNC_STAGES   = 2;
  localparam int SETTLE_CYCLES = 3;

endpackage

// File: rtl/cdc_edge_sync.sv
// Brings an asynchronous level into the local clock domain and emits a
// one-cycle pulse whenever the synchronised level changes.
module cdc_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              edge_q;

  // Synchroniser chain, compare register and a registered change pulse so
  // downstream counters see a clean flop output three cycles after the input moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
      edge_q <= sync_q[STAGES-1] ^ prev_q;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/clock_monitor.sv
// Counts transitions of a divided-down foreign clock over a fixed window of
// usb_clk cycles and reports the result plus a clock-present indication.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int GATE_CYCLES    = 96000,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 usb_clk,
  input  logic                 reset,
  input  logic                 I_meas_toggle,
  input  logic                 I_enable,
  input  logic                 I_restart,
  output logic [CNT_WIDTH-1:0] O_freq_count,
  output logic                 O_count_valid,
  output logic                 O_overflow,
  output logic                 O_clk_present
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int SET_W  = $clog2(SETTLE_CYCLES);

  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [SET_W-1:0]     settle_q;
  logic [GATE_W-1:0]    gate_q;
  logic [CNT_WIDTH-1:0] edge_cnt_q;
  logic                 win_ovf_q;
  logic [TMO_W-1:0]     tmo_q;

  logic                 toggle_edge;
  logic                 enter_settle;
  logic                 enter_gate;
  logic                 in_gate;
  logic                 terminal;
  logic                 edge_at_max;
  logic                 edge_ovf_now;
  logic [CNT_WIDTH-1:0] edge_cnt_inc;

  cdc_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (usb_clk),
    .rst        (reset),
    .async_in   (I_meas_toggle),
    .edge_pulse (toggle_edge)
  );

  // Saturating view of the edge counter with the current edge folded in.
  assign edge_at_max  = (edge_cnt_q == '1);
  assign edge_ovf_now = toggle_edge & edge_at_max;
  assign edge_cnt_inc = (toggle_edge && !edge_at_max) ? edge_cnt_q + CNT_WIDTH'(1) : edge_cnt_q;

  // FSM state register.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and window control; disable beats restart, restart beats the window close.
  always_comb begin
    state_d      = state_q;
    enter_settle = 1'b0;
    enter_gate   = 1'b0;
    in_gate      = 1'b0;
    terminal     = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_enable) begin
          state_d      = SETTLE;
          enter_settle = 1'b1;
        end
      end
      SETTLE: begin
        if (!I_enable) begin
          state_d = IDLE;
        end else if (I_restart) begin
          enter_settle = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d    = GATE;
          enter_gate = 1'b1;
        end
      end
      GATE: begin
        if (!I_enable) begin
          state_d = IDLE;
        end else if (I_restart) begin
          state_d      = SETTLE;
          enter_settle = 1'b1;
        end else begin
          in_gate  = 1'b1;
          terminal = (gate_q == '0);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Settle timer: gives the synchroniser time to flush before a window opens.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
    end else if (enter_settle) begin
      settle_q <= '0;
    end else if (state_q == SETTLE && state_d == SETTLE) begin
      settle_q <= settle_q + SET_W'(1);
    end
  end

  // Gate window counters; reload at window open and at each window close so windows abut.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      gate_q     <= '0;
      edge_cnt_q <= '0;
      win_ovf_q  <= 1'b0;
    end else if (enter_gate || terminal) begin
      gate_q     <= GATE_LAST;
      edge_cnt_q <= '0;
      win_ovf_q  <= 1'b0;
    end else if (in_gate) begin
      gate_q     <= gate_q - GATE_W'(1);
      edge_cnt_q <= edge_cnt_inc;
      win_ovf_q  <= win_ovf_q | edge_ovf_now;
    end else begin
      gate_q     <= '0;
      edge_cnt_q <= '0;
      win_ovf_q  <= 1'b0;
    end
  end

  // Published result registers change only together with the valid pulse.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      O_freq_count  <= '0;
      O_overflow    <= 1'b0;
      O_count_valid <= 1'b0;
    end else begin
      O_count_valid <= terminal;
      if (terminal) begin
        O_freq_count <= edge_cnt_inc;
        O_overflow   <= win_ovf_q | edge_ovf_now;
      end
    end
  end

  // Presence detector runs all the time, independent of the gating FSM.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      tmo_q         <= '0;
      O_clk_present <= 1'b0;
    end else if (toggle_edge) begin
      tmo_q         <= '0;
      O_clk_present <= 1'b1;
    end else begin
      if (tmo_q != TMO_LAST) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end else begin
        O_clk_present <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: a 32-bit instance for the main scenarios
// and a 4-bit instance for counter saturation.
module tb_clock_monitor;
  import clock_monitor_pkg::*;

  localparam int G = 100;
  localparam int T = 16;

  typedef struct {
    int   at;
    int   cnt;
    logic ovf;
  } exp_t;

  logic        usb_clk;
  logic        reset;
  logic        meas_toggle;
  logic        enable;
  logic        restart;
  logic [31:0] freq_count;
  logic        count_valid;
  logic        overflow;
  logic        clk_present;

  logic        ovf_enable;
  logic        ovf_restart;
  logic [3:0]  ovf_count;
  logic        ovf_valid;
  logic        ovf_overflow;
  logic        ovf_present;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   tog_period = 0;
  int   tog_phase = 0;
  exp_t q_main[$];
  exp_t q_ovf[$];
  exp_t mon_e;

  clock_monitor #(.GATE_CYCLES(G), .CNT_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .usb_clk       (usb_clk),
    .reset         (reset),
    .I_meas_toggle (meas_toggle),
    .I_enable      (enable),
    .I_restart     (restart),
    .O_freq_count  (freq_count),
    .O_count_valid (count_valid),
    .O_overflow    (overflow),
    .O_clk_present (clk_present)
  );

  clock_monitor #(.GATE_CYCLES(G), .CNT_WIDTH(4), .TIMEOUT_CYCLES(T)) dut_ovf (
    .usb_clk       (usb_clk),
    .reset         (reset),
    .I_meas_toggle (meas_toggle),
    .I_enable      (ovf_enable),
    .I_restart     (ovf_restart),
    .O_freq_count  (ovf_count),
    .O_count_valid (ovf_valid),
    .O_overflow    (ovf_overflow),
    .O_clk_present (ovf_present)
  );

  initial begin
    usb_clk = 1'b0;
    forever #5 usb_clk = ~usb_clk;
  end

  // Cycle index: value n holds from rising edge n to rising edge n+1.
  always @(posedge usb_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic stepToggle();
    if (tog_period != 0) begin
      tog_phase++;
      if (tog_phase >= tog_period) begin
        meas_toggle = ~meas_toggle;
        tog_phase   = 0;
      end
    end
  endtask

  // Advance to just after the rising edge that starts cycle n, running the toggle source.
  task automatic gotoCycle(input int n);
    while (cyc < n) begin
      @(posedge usb_clk);
      #1;
      stepToggle();
    end
  endtask

  task automatic applyStimulus(input int at_cycle, input logic en, input logic rs);
    gotoCycle(at_cycle);
    enable  = en;
    restart = rs;
    if (rs) begin
      gotoCycle(at_cycle + 1);
      restart = 1'b0;
    end
  endtask

  task automatic pushMain(input int at, input int cnt, input logic ovf);
    exp_t e;
    e.at = at; e.cnt = cnt; e.ovf = ovf;
    q_main.push_back(e);
  endtask

  task automatic pushOvf(input int at, input int cnt, input logic ovf);
    exp_t e;
    e.at = at; e.cnt = cnt; e.ovf = ovf;
    q_ovf.push_back(e);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected window.
  always @(negedge usb_clk) begin
    if (count_valid) begin
      if (q_main.size() == 0) begin
        checkOutput("main_unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = q_main.pop_front();
        checkOutput("main_valid_cycle", 32'(cyc), 32'(mon_e.at));
        checkOutput("main_count", freq_count, 32'(mon_e.cnt));
        checkOutput("main_overflow", 32'(overflow), 32'(mon_e.ovf));
      end
    end
    if (ovf_valid) begin
      if (q_ovf.size() == 0) begin
        checkOutput("ovf_unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = q_ovf.pop_front();
        checkOutput("ovf_valid_cycle", 32'(cyc), 32'(mon_e.at));
        checkOutput("ovf_count", 32'(ovf_count), 32'(mon_e.cnt));
        checkOutput("ovf_overflow", 32'(ovf_overflow), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    int e;
    int r;
    int d;
    int rel;

    reset       = 1'b1;
    meas_toggle = 1'b0;
    enable      = 1'b0;
    restart     = 1'b0;
    ovf_enable  = 1'b0;
    ovf_restart = 1'b0;

    // Reset state
    gotoCycle(1);
    checkOutput("rst_count", freq_count, 32'd0);
    checkOutput("rst_valid", 32'(count_valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_present", 32'(clk_present), 32'd0);
    checkOutput("rst_ovf_count", 32'(ovf_count), 32'd0);
    gotoCycle(3);
    reset = 1'b0;
    gotoCycle(10);
    checkOutput("idle_present", 32'(clk_present), 32'd0);
    checkOutput("idle_count", freq_count, 32'd0);

    // Absent clock: windows still close, with zero count
    e = 12;
    pushMain(e + 4 + G, 0, 1'b0);
    pushMain(e + 4 + 2 * G, 0, 1'b0);
    applyStimulus(e, 1'b1, 1'b0);
    applyStimulus(e + 4 + 2 * G + 4, 1'b0, 1'b0);
    gotoCycle(e + 4 + 2 * G + 10);
    checkOutput("absent_all_valids_seen", 32'(q_main.size()), 32'd0);
    checkOutput("absent_present", 32'(clk_present), 32'd0);

    // Single toggle flip: present rises 4 cycles later, drops 16 cycles after that
    gotoCycle(230);
    meas_toggle = ~meas_toggle;
    gotoCycle(233);
    checkOutput("present_before", 32'(clk_present), 32'd0);
    gotoCycle(234);
    checkOutput("present_rise", 32'(clk_present), 32'd1);
    gotoCycle(249);
    checkOutput("present_hold", 32'(clk_present), 32'd1);
    gotoCycle(250);
    checkOutput("present_fall", 32'(clk_present), 32'd0);

    // Nominal rate: flip every 4 cycles gives 25 per window
    gotoCycle(260);
    tog_period = 4;
    tog_phase  = 0;
    e = 270;
    pushMain(e + 4 + G, 25, 1'b0);
    pushMain(e + 4 + 2 * G, 25, 1'b0);
    pushMain(e + 4 + 3 * G, 25, 1'b0);
    applyStimulus(e, 1'b1, 1'b0);
    gotoCycle(e + 4 + 3 * G + 1);
    checkOutput("nominal_all_valids_seen", 32'(q_main.size()), 32'd0);
    checkOutput("nominal_present", 32'(clk_present), 32'd1);

    // Restart 50 cycles into a window: that window is dropped
    r = e + 4 + 3 * G + 50;
    pushMain(r + 4 + G, 25, 1'b0);
    applyStimulus(r, 1'b1, 1'b1);
    gotoCycle(r + 4 + G + 1);
    checkOutput("restart_valid_seen", 32'(q_main.size()), 32'd0);

    // Enable drop mid-window: IDLE next cycle, result registers hold
    d = r + 4 + G + 30;
    applyStimulus(d, 1'b0, 1'b0);
    gotoCycle(d + 1);
    checkOutput("drop_state_idle", 32'(dut.state_q), 32'(IDLE));
    gotoCycle(d + 150);
    checkOutput("drop_count_hold", freq_count, 32'd25);
    checkOutput("drop_overflow_hold", 32'(overflow), 32'd0);
    checkOutput("drop_no_valid", 32'(q_main.size()), 32'd0);

    // Saturation on the 4-bit instance, then a slower rate clears overflow
    gotoCycle(d + 155);
    tog_period = 2;
    tog_phase  = 0;
    e = d + 165;
    pushOvf(e + 4 + G, 15, 1'b1);
    pushOvf(e + 4 + 2 * G, 10, 1'b0);
    gotoCycle(e);
    ovf_enable = 1'b1;
    gotoCycle(e + 64);
    tog_period = 10;
    tog_phase  = 0;
    gotoCycle(e + 4 + 2 * G + 6);
    ovf_enable = 1'b0;
    checkOutput("ovf_all_valids_seen", 32'(q_ovf.size()), 32'd0);

    // Async reset in the middle of a gate window
    tog_period = 4;
    tog_phase  = 0;
    e = cyc + 10;
    pushMain(e + 4 + G, 25, 1'b0);
    applyStimulus(e, 1'b1, 1'b0);
    gotoCycle(e + 4 + G + 46);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_count", freq_count, 32'd0);
    checkOutput("arst_valid", 32'(count_valid), 32'd0);
    checkOutput("arst_overflow", 32'(overflow), 32'd0);
    checkOutput("arst_present", 32'(clk_present), 32'd0);
    checkOutput("arst_ovf_count", 32'(ovf_count), 32'd0);
    checkOutput("arst_pending", 32'(q_main.size()), 32'd0);
    q_main.delete();
    q_ovf.delete();
    rel = e + 4 + G + 51;
    gotoCycle(rel);
    reset = 1'b0;
    pushMain(rel + 4 + G, 25, 1'b0);
    gotoCycle(rel + 4 + G + 6);
    checkOutput("arst_first_valid_seen", 32'(q_main.size()), 32'd0);
    checkOutput("arst_ovf_quiet", 32'(q_ovf.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Measures the frequency of the crypto/CW clock from inside the `usb_clk` domain and reports whether that clock is running. The measured domain supplies a divide-by-2 toggle, which flips once per measured-clock rising edge. This block synchronises the toggle, counts its transitions over a fixed gate window of `usb_clk` cycles, and publishes the count to the register interface. It sits beside the clock-selection logic and lets the host confirm which source drives the crypto clock and at what rate.

## Interface
- `GATE_CYCLES`, 96000: gate window length in `usb_clk` cycles (1 ms at 96 MHz).
- `CNT_WIDTH`, 32: width of the edge counter and of `O_freq_count`.
- `TIMEOUT_CYCLES`, 1024: number of `usb_clk` cycles without an edge before the clock is declared absent.
- `usb_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `I_meas_toggle`  in  1  toggle from the measured domain; asynchronous to `usb_clk`.
- `I_enable`  in  1  level; run gate windows back-to-back while high.
- `I_restart`  in  1  single-cycle pulse; abort the current window and start a new one.
- `O_freq_count`  out  CNT_WIDTH  measured-clock cycles counted in the last completed window.
- `O_count_valid`  out  1  one-cycle pulse when `O_freq_count` updates.
- `O_overflow`  out  1  the last completed window saturated the counter.
- `O_clk_present`  out  1  a toggle edge was seen within the last `TIMEOUT_CYCLES`.

## Operation
- **Synchroniser and edge detect:** `I_meas_toggle` passes through a 2-FF synchroniser, then one compare register. `edge` = sync XOR prev. Each edge counts as one measured-clock cycle.
- **Input limit:** each toggle level must be held for at least 2 `usb_clk` cycles, so the measured clock must be ≤ `usb_clk`/2. Faster inputs under-count; this is not flagged.
- **FSM states:** IDLE, SETTLE, GATE.
- **IDLE:**
  - Counters are held at 0.
  - `I_enable`=1 moves to SETTLE.
- **SETTLE:**
  - Lasts exactly 3 cycles, which flushes stale synchroniser state. Edges are ignored.
  - The state then moves to GATE with gate counter = `GATE_CYCLES`-1 and edge counter = 0.
- **GATE:**
  - Every cycle: the gate counter decrements and the edge counter adds `edge`.
  - The edge counter saturates at all-ones. On saturation a window-overflow flag is set.
  - **Terminal cycle (gate counter = 0):**
    - `O_freq_count` ← edge counter + `edge`, saturating; the edge from the last cycle is included.
    - `O_overflow` ← window flag.
    - `O_count_valid` pulses.
    - Edge counter, window flag and gate counter reload.
    - The state stays in GATE with no dead cycle between windows.
- **`I_enable`=0 in SETTLE or GATE:** go to IDLE next cycle. The partial window is discarded and `O_freq_count`/`O_overflow` hold their values.
- **`I_restart` in SETTLE or GATE:** go to SETTLE and clear the edge counter. No valid pulse is produced for the aborted window. `I_restart` in IDLE is ignored.
- **Simultaneous events:**
  - `I_enable`=0 has priority over `I_restart`.
  - `I_restart` has priority over the terminal-cycle latch; the window is discarded.
- **Presence detector** (independent of the FSM and of `I_enable`):
  - The timeout counter clears on `edge`, otherwise increments and saturates at `TIMEOUT_CYCLES`-1.
  - `O_clk_present` goes to 1 the cycle after any edge.
  - `O_clk_present` goes to 0 when the counter reaches `TIMEOUT_CYCLES`-1.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; all counters and synchroniser flops 0.
- **Latency:** a toggle transition reaches `edge` 3 cycles later (2 sync + 1 compare).
- **First valid:** the enable rising edge is sampled at cycle 0. SETTLE covers cycles 1–3 and GATE covers cycles 4 to 3+`GATE_CYCLES`. `O_count_valid` is high in cycle 4+`GATE_CYCLES`.
- **Later valids:** exactly every `GATE_CYCLES` cycles.
- **Output registers:** `O_freq_count` and `O_overflow` change only in the same cycle that `O_count_valid` is high. They are stable at all other times.
- **Mid-operation reset:** takes effect immediately and asynchronously. Outputs go to their reset values and no valid pulse is generated.

## Structure
- Package `clock_monitor_pkg` holds:
  - the state encoding (IDLE=2'd0, SETTLE=2'd1, GATE=2'd2);
  - `SYNC_STAGES`=2;
  - `SETTLE_CYCLES`=3.
- Sub-module `cdc_edge_sync` contains the synchroniser, the compare register and the `edge` output. It is reusable for other async status inputs.
- The gate counter width is $clog2(`GATE_CYCLES`). The timeout counter width is $clog2(`TIMEOUT_CYCLES`).

## Test plan
Bench parameters: `GATE_CYCLES`=100, `TIMEOUT_CYCLES`=16.

- **Nominal rate:** toggle flips every 4 cycles, enable high → `O_freq_count`=25 and `O_overflow`=0 each window. First valid at cycle 104, then every 100 cycles.
- **Absent clock:** no toggle, enable high → `O_freq_count`=0 with a valid pulse each window. `O_clk_present`=0 from reset. A single toggle flip gives `O_clk_present`=1 four cycles later and 0 again 16 cycles after that.
- **Restart:** `I_restart` 50 cycles into a window → no valid for that window. The next valid arrives 104 cycles after the restart cycle, with count 25 at the nominal rate.
- **Overflow:** `CNT_WIDTH`=4, toggle every 2 cycles → `O_freq_count`=15, `O_overflow`=1. Then slow the toggle to every 10 cycles → the next window gives 10 with `O_overflow`=0.
- **Enable drop:** deassert `I_enable` mid-window → FSM in IDLE next cycle, no valid pulse, `O_freq_count` holds the previous value.
- **Async reset mid-GATE:** all outputs go to 0 immediately. After reset, `I_enable` sampled high at cycle 0 gives the first valid at cycle 104.
